// File: rtl/eth_tx_sched_if.sv
// eth_tx_sched_if: packet-type request to the frame sender and the sender stream it reports back
interface eth_tx_sched_if;
  logic [3:0] o_pkt_type;
  logic i_sop;
  logic i_eop;
  logic i_vld;
  logic i_rdy;
  modport master (output o_pkt_type, input i_sop, i_eop, i_vld, i_rdy);
  modport slave (input o_pkt_type, output i_sop, i_eop, i_vld, i_rdy);
endinterface

// File: rtl/eth_tx_sched.sv
// eth_tx_sched: arbitrates ARP resp/ARP req/UDP fragments onto the sender's packet type (ETH_TX_SCHED_STATS_EN adds event counters)
module eth_tx_sched #(
  parameter int GAP_CYCLES = 16,
  parameter int ISSUE_TIMEOUT = 64,
  parameter int FRAGS_PER_BLOCK = 4,
  parameter logic [23:0] ARP_RETRY = 24'd12500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_arp_resp_req,
  input  logic i_udp_req,
  input  logic i_mac_valid,
  eth_tx_sched_if.master tx,
  output logic o_busy,
  output logic o_udp_drop,
  output logic o_err
`ifdef ETH_TX_SCHED_STATS_EN
  ,
  output logic [15:0] o_cnt_arp,
  output logic [15:0] o_cnt_udp,
  output logic [7:0] o_cnt_err
`endif
);
  localparam int CMAX = ISSUE_TIMEOUT > GAP_CYCLES ? ISSUE_TIMEOUT : GAP_CYCLES;
  localparam int CW = $clog2(CMAX) + 1;
  localparam int FW = $clog2(FRAGS_PER_BLOCK) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, GAP} state_t;
  state_t state_q, state_d;
  logic [3:0] type_q, type_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] frag_q, frag_d;
  logic [23:0] tmr_q, tmr_d;
  logic resp_q, resp_d, req_q, req_d, udp_q, udp_d, drop_q, drop_d, err_q, err_d;
  logic sop_acc, eop_acc, eop_done, timeout, udp_active, udp_new, udp_abort, udp_elig, frag_last, tmr_hit;
  assign sop_acc = tx.i_sop & tx.i_vld & tx.i_rdy;
  assign eop_acc = tx.i_eop & tx.i_vld & tx.i_rdy;
  assign eop_done = state_q == BUSY && eop_acc;
  assign timeout = state_q == ISSUE && !sop_acc && cnt_q == CW'(ISSUE_TIMEOUT - 1);
  assign udp_active = (state_q == ISSUE || state_q == BUSY) && type_q == 4'd3;
  assign udp_new = i_udp_req & i_mac_valid;
  // a block whose MAC went away is abandoned, but only once any fragment already on the wire has finished
  assign udp_abort = udp_q & ~i_mac_valid & ~udp_active;
  assign udp_elig = udp_q & i_mac_valid;
  assign frag_last = frag_q == FW'(FRAGS_PER_BLOCK - 1);
  assign tmr_hit = ~i_mac_valid & ~req_q & (tmr_q == ARP_RETRY - 24'd1);
  assign tx.o_pkt_type = type_q;
  assign o_busy = state_q != IDLE;
  assign o_udp_drop = drop_q;
  assign o_err = err_q;
  // packet sequencing: pick a winner in IDLE, wait for sop, wait for eop, then hold type 0 for the gap
  always_comb begin
    state_d = state_q;
    type_d = type_q;
    cnt_d = cnt_q;
    err_d = timeout;
    case (state_q)
      IDLE: begin
        type_d = resp_q ? 4'd2 : req_q ? 4'd1 : udp_elig ? 4'd3 : 4'd0;
        cnt_d = '0;
        state_d = (resp_q | req_q | udp_elig) ? ISSUE : IDLE;
      end
      ISSUE: begin
        cnt_d = cnt_q + CW'(1);
        if (sop_acc) state_d = BUSY;
        else if (timeout) begin
          state_d = GAP;
          type_d = 4'd0;
          cnt_d = '0;
        end
      end
      BUSY: if (eop_acc) begin
        state_d = GAP;
        type_d = 4'd0;
        cnt_d = '0;
      end
      default: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(GAP_CYCLES - 1)) state_d = IDLE;
      end
    endcase
  end
  // pending flags, ARP retry timer and UDP fragment bookkeeping; a new request outranks a same-cycle clear
  always_comb begin
    resp_d = i_arp_resp_req | (resp_q & ~(eop_done && type_q == 4'd2));
    req_d = tmr_hit | (req_q & ~(eop_done && type_q == 4'd1));
    tmr_d = (i_mac_valid || tmr_hit) ? '0 : req_q ? tmr_q : tmr_q + 24'd1;
    frag_d = frag_q;
    udp_d = udp_q;
    drop_d = udp_abort | (i_udp_req & (~i_mac_valid | udp_q));
    if (eop_done && type_q == 4'd3) begin
      frag_d = frag_last ? '0 : frag_q + FW'(1);
      udp_d = ~frag_last;
    end
    if (udp_abort) begin
      frag_d = '0;
      udp_d = 1'b0;
    end
    if (udp_new) begin
      frag_d = '0;
      udp_d = 1'b1;
    end
  end
  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      type_q <= '0;
      cnt_q <= '0;
      frag_q <= '0;
      tmr_q <= '0;
      resp_q <= 1'b0;
      req_q <= 1'b0;
      udp_q <= 1'b0;
      drop_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q <= type_d;
      cnt_q <= cnt_d;
      frag_q <= frag_d;
      tmr_q <= tmr_d;
      resp_q <= resp_d;
      req_q <= req_d;
      udp_q <= udp_d;
      drop_q <= drop_d;
      err_q <= err_d;
    end
  end
`ifdef ETH_TX_SCHED_STATS_EN
  logic [15:0] arpc_q, arpc_d, udpc_q, udpc_d;
  logic [7:0] errc_q, errc_d;
  // saturating event counters
  always_comb begin
    arpc_d = arpc_q + ((eop_done && type_q != 4'd3 && ~&arpc_q) ? 16'd1 : 16'd0);
    udpc_d = udpc_q + ((eop_done && type_q == 4'd3 && ~&udpc_q) ? 16'd1 : 16'd0);
    errc_d = errc_q + ((timeout && ~&errc_q) ? 8'd1 : 8'd0);
  end
  // counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arpc_q <= '0;
      udpc_q <= '0;
      errc_q <= '0;
    end else begin
      arpc_q <= arpc_d;
      udpc_q <= udpc_d;
      errc_q <= errc_d;
    end
  end
  assign o_cnt_arp = arpc_q;
  assign o_cnt_udp = udpc_q;
  assign o_cnt_err = errc_q;
`endif
endmodule
